// File: rtl/float_add_pipe.sv
// Three-stage pipelined adder for unsigned mini-floats {exp, man}, value = man * 2^exp.
// Optional saturation indicator output enabled by FLOAT_ADD_PIPE_SAT_FLAG_EN.
module float_add_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 5,
    parameter int W     = EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
    output logic         sat_flag,
`endif
    output logic [W-1:0] result
);

    logic             adv;

    logic             s1_valid_q;
    logic [EXP_W-1:0] s1_exp_big_q,   s1_exp_big_d;
    logic [EXP_W-1:0] s1_dist_q,      s1_dist_d;
    logic [MAN_W-1:0] s1_man_big_q,   s1_man_big_d;
    logic [MAN_W-1:0] s1_man_small_q, s1_man_small_d;

    logic             s2_valid_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MAN_W:0]   s2_sum_q,       s2_sum_d;

    logic             s3_valid_q;
    logic [W-1:0]     result_q,       result_d;
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
    logic             sat_q,          sat_d;
`endif

    // One stall signal for the whole pipe: bubbles shift like data.
    assign adv       = ~s3_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_valid_q;
    assign result    = result_q;
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
    assign sat_flag  = sat_q;
`endif

    always_comb begin
        logic [EXP_W-1:0] exp_a, exp_b;
        logic [MAN_W-1:0] man_a, man_b;
        exp_a = a_in[W-1:MAN_W];
        exp_b = b_in[W-1:MAN_W];
        man_a = a_in[MAN_W-1:0];
        man_b = b_in[MAN_W-1:0];
        if (exp_a >= exp_b) begin
            s1_exp_big_d   = exp_a;
            s1_man_big_d   = man_a;
            s1_man_small_d = man_b;
            s1_dist_d      = exp_a - exp_b;
        end else begin
            s1_exp_big_d   = exp_b;
            s1_man_big_d   = man_b;
            s1_man_small_d = man_a;
            s1_dist_d      = exp_b - exp_a;
        end
    end

    // A logical shift by MAN_W or more already yields zero, covering large distances.
    always_comb begin
        logic [MAN_W-1:0] man_sh;
        man_sh   = s1_man_small_q >> s1_dist_q;
        s2_sum_d = {1'b0, s1_man_big_q} + {1'b0, man_sh};
    end

    always_comb begin
        result_d = {s2_exp_q, s2_sum_q[MAN_W-1:0]};
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
        sat_d    = 1'b0;
`endif
        if (s2_sum_q[MAN_W]) begin
            if (s2_exp_q != {EXP_W{1'b1}}) begin
                result_d = {s2_exp_q + 1'b1, 1'b1, s2_sum_q[MAN_W-1:1]};
            end else begin
                result_d = {W{1'b1}};
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
                sat_d    = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_exp_big_q   <= '0;
            s1_dist_q      <= '0;
            s1_man_big_q   <= '0;
            s1_man_small_q <= '0;
            s2_valid_q     <= 1'b0;
            s2_exp_q       <= '0;
            s2_sum_q       <= '0;
            s3_valid_q     <= 1'b0;
            result_q       <= '0;
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
            sat_q          <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid_q     <= in_valid;
            s1_exp_big_q   <= s1_exp_big_d;
            s1_dist_q      <= s1_dist_d;
            s1_man_big_q   <= s1_man_big_d;
            s1_man_small_q <= s1_man_small_d;
            s2_valid_q     <= s1_valid_q;
            s2_exp_q       <= s1_exp_big_q;
            s2_sum_q       <= s2_sum_d;
            s3_valid_q     <= s2_valid_q;
            result_q       <= result_d;
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
            sat_q          <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_float_add_pipe.sv
// Scoreboard bench for float_add_pipe (EXP_W=3, MAN_W=5) with hand-computed vectors.
module tb_float_add_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
    logic       sat_flag;
`endif

    float_add_pipe #(.EXP_W(3), .MAN_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
        .sat_flag  (sat_flag),
`endif
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       sat;
        bit         chk_lat;
        int         t_in;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic sat, input bit chk_lat);
        exp_t e;
        int   n;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        e.res = res;
        e.sat = sat;
        e.chk_lat = chk_lat;
        e.t_in = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pops on each accepted output, and watches stall stability.
    bit         prev_stall = 0;
    logic [7:0] prev_res;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", int'(out_valid), 1);
                    check("stall_result_held", int'(result), int'(prev_res));
                end
                prev_stall = 0;
                if (out_valid && !out_ready) begin
                    check("in_ready_low_in_stall", int'(in_ready), 0);
                    prev_stall = 1;
                    prev_res = result;
                end else if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("result", int'(result), int'(e.res));
`ifdef FLOAT_ADD_PIPE_SAT_FLAG_EN
                        check("sat_flag", int'(sat_flag), int'(e.sat));
`endif
                        if (e.chk_lat) check("latency_edges", cyc - e.t_in, 2);
                    end
                end
            end
        end
    end

    initial begin
        #2;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Isolated vectors, each drained before the next.
        send(8'h2A, 8'h05, 8'h2C, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'h05, 8'h2A, 8'h2C, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'h21, 8'h22, 8'h23, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'h3F, 8'h21, 8'h50, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'hE1, 8'h1F, 8'hE1, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'hFF, 8'hE1, 8'hFF, 1'b1, 1'b1); repeat (5) @(posedge clk); #1;
        send(8'h00, 8'h47, 8'h47, 1'b0, 1'b1); repeat (5) @(posedge clk); #1;

        // Back-to-back stream with a downstream stall window.
        fork
            begin
                send(8'h2A, 8'h05, 8'h2C, 1'b0, 1'b0);
                send(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
                send(8'h3F, 8'h21, 8'h50, 1'b0, 1'b0);
                send(8'hFF, 8'hE1, 8'hFF, 1'b1, 1'b0);
                send(8'h40, 8'h41, 8'h41, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("stream_drained", q.size(), 0);

        // Reset while one result is presented and another is in flight.
        send(8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        send(8'h3F, 8'h21, 8'h50, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_result", int'(result), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(8'h2A, 8'h05, 8'h2C, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
